// File: rtl/ray_dir_sequencer.sv
// Per-frame ray-direction sequencer: walks NUM_COLS columns across a FOV arc, sharing one cosine LUT.
// Optional fisheye-correction lookup is enabled by defining RAY_FISHEYE_CORR_EN.
module ray_dir_sequencer #(
    parameter int unsigned NUM_COLS = 320,
    parameter int unsigned FOV      = 60
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [8:0]        heading,
    output logic [8:0]        lut_angle,
    input  logic signed [9:0] lut_val,
    output logic              dir_valid,
    input  logic              dir_ready,
    output logic signed [9:0] dir_x,
    output logic signed [9:0] dir_y,
    output logic [8:0]        ray_angle,
    output logic [9:0]        col,
    output logic signed [9:0] corr,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned AW       = $clog2(NUM_COLS) + 1;
    localparam logic [9:0]  HALF_FOV = 10'(FOV / 2);
    localparam logic [9:0]  LAST_COL = 10'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCos,
        StSin,
        StCorr,
        StOut,
        StDone
    } state_e;

    state_e               r_state;
    logic [8:0]           r_a;
    logic [9:0]           r_col;
    logic [AW-1:0]        r_acc;
    logic signed [9:0]    r_dir_x;
    logic signed [9:0]    r_dir_y;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_armed;

    logic [8:0]           w_a_start;
    logic [8:0]           w_a_sin;
    logic [8:0]           w_a_inc;
    logic [AW-1:0]        w_acc_sum;

    // Operands are always < 720, so one conditional subtract reduces mod 360.
    function automatic logic [8:0] f_mod360(input logic [9:0] v);
        return (v >= 10'd360) ? 9'(v - 10'd360) : v[8:0];
    endfunction

    assign w_a_start = f_mod360({1'b0, heading} + 10'd360 - HALF_FOV);
    assign w_a_sin   = f_mod360({1'b0, r_a} + 10'd270);
    assign w_a_inc   = f_mod360({1'b0, r_a} + 10'd1);
    assign w_acc_sum = r_acc + AW'(FOV);

`ifdef RAY_FISHEYE_CORR_EN
    logic [8:0]           r_hd;
    logic signed [9:0]    r_corr;
    logic [8:0]           w_a_corr;

    assign w_a_corr = f_mod360({1'b0, r_a} + 10'd360 - {1'b0, r_hd});
    assign corr     = r_corr;
`else
    assign corr     = 10'sd32;
`endif

    always_comb begin
        lut_angle = 9'd0;
        unique case (r_state)
            StCos:   lut_angle = r_a;
            StSin:   lut_angle = w_a_sin;
`ifdef RAY_FISHEYE_CORR_EN
            StCorr:  lut_angle = w_a_corr;
`endif
            default: lut_angle = 9'd0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= StIdle;
            r_a     <= 9'd0;
            r_col   <= 10'd0;
            r_acc   <= '0;
            r_dir_x <= 10'sd0;
            r_dir_y <= 10'sd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_armed <= 1'b0;
`ifdef RAY_FISHEYE_CORR_EN
            r_hd    <= 9'd0;
            r_corr  <= 10'sd32;
`endif
        end else begin
            // Blocks a start that coincides with reset release.
            r_armed <= 1'b1;
            r_done  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start && r_armed) begin
                        r_a     <= w_a_start;
                        r_col   <= 10'd0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StCos;
`ifdef RAY_FISHEYE_CORR_EN
                        r_hd    <= heading;
`endif
                    end
                end
                StCos: begin
                    r_dir_x <= lut_val;
                    r_state <= StSin;
                end
                StSin: begin
                    r_dir_y <= lut_val;
`ifdef RAY_FISHEYE_CORR_EN
                    r_state <= StCorr;
`else
                    r_valid <= 1'b1;
                    r_state <= StOut;
`endif
                end
`ifdef RAY_FISHEYE_CORR_EN
                StCorr: begin
                    r_corr  <= lut_val;
                    r_valid <= 1'b1;
                    r_state <= StOut;
                end
`endif
                StOut: begin
                    if (dir_ready) begin
                        r_valid <= 1'b0;
                        if (r_col == LAST_COL) begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_col <= r_col + 10'd1;
                            if (w_acc_sum >= AW'(NUM_COLS)) begin
                                r_acc <= w_acc_sum - AW'(NUM_COLS);
                                r_a   <= w_a_inc;
                            end else begin
                                r_acc <= w_acc_sum;
                            end
                            r_state <= StCos;
                        end
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign dir_valid  = r_valid;
    assign dir_x      = r_dir_x;
    assign dir_y      = r_dir_y;
    assign ray_angle  = r_a;
    assign col        = r_col;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule

// File: tb/tb_ray_dir_sequencer.sv
// Scoreboard bench for ray_dir_sequencer: a round(32*cos) LUT model feeds the DUT; expected
// beats are queued at each accepted start and compared on every handshake.
module tb_ray_dir_sequencer;

    localparam int NUM_COLS = 320;
    localparam int FOV      = 60;
`ifdef RAY_FISHEYE_CORR_EN
    localparam int CPB = 4;
`else
    localparam int CPB = 3;
`endif
    localparam real PI = 3.14159265358979;

    typedef struct {
        int c;
        int ang;
        int x;
        int y;
        int cr;
    } beat_t;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b1;
    logic              start = 1'b0;
    logic [8:0]        heading = 9'd0;
    logic [8:0]        lut_angle;
    logic signed [9:0] lut_val;
    logic              dir_valid;
    logic              dir_ready = 1'b1;
    logic signed [9:0] dir_x;
    logic signed [9:0] dir_y;
    logic [8:0]        ray_angle;
    logic [9:0]        col;
    logic signed [9:0] corr;
    logic              busy;
    logic              frame_done;

    logic signed [9:0] cos_tab [0:359];
    beat_t             sb[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int beats = 0;
    int dones = 0;
    int t0, b0, d0;

    ray_dir_sequencer #(
        .NUM_COLS(NUM_COLS),
        .FOV     (FOV)
    ) u_dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .heading   (heading),
        .lut_angle (lut_angle),
        .lut_val   (lut_val),
        .dir_valid (dir_valid),
        .dir_ready (dir_ready),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .ray_angle (ray_angle),
        .col       (col),
        .corr      (corr),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        lut_val = 10'sd0;
        if (lut_angle < 9'd360) lut_val = cos_tab[lut_angle];
    end

    function automatic int rnd32(input real v);
        real s;
        s = 32.0 * v;
        if (s >= 0.0) return $rtoi(s + 0.5);
        return -$rtoi(-s + 0.5);
    endfunction

    function automatic real rad(input int d);
        return real'(d) * PI / 180.0;
    endfunction

    function automatic int exp_angle(input int hd, input int c);
        return (hd + 360 - FOV / 2 + (c * FOV) / NUM_COLS) % 360;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int hd);
        beat_t e;
        for (int c = 0; c < NUM_COLS; c++) begin
            e.c   = c;
            e.ang = exp_angle(hd, c);
            e.x   = rnd32($cos(rad(e.ang)));
            e.y   = rnd32($sin(rad(e.ang)));
`ifdef RAY_FISHEYE_CORR_EN
            e.cr  = rnd32($cos(rad(e.ang - hd)));
`else
            e.cr  = 32;
`endif
            sb.push_back(e);
        end
    endtask

    // Checks the beat the next rising edge will take, then advances to just after the falling edge.
    task automatic step();
        beat_t e;
        if (dir_valid && dir_ready) begin
            beats++;
            chk("sb_has_entry", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("col", int'(col), e.c);
                chk("ray_angle", int'(ray_angle), e.ang);
                chk("dir_x", int'($signed(dir_x)), e.x);
                chk("dir_y", int'($signed(dir_y)), e.y);
                chk("corr", int'($signed(corr)), e.cr);
            end
        end
        @(negedge Clk);
        #1;
        cyc++;
        if (frame_done) dones++;
    endtask

    task automatic wait_col(input int c);
        int n = 0;
        while (int'(col) != c && n < 5000) begin
            step();
            n++;
        end
        chk("wait_col", int'(col), c);
    endtask

    task automatic start_frame(input int hd);
        heading = 9'(hd);
        start   = 1'b1;
        t0 = cyc;
        b0 = beats;
        d0 = dones;
        push_frame(hd);
        step();
        start = 1'b0;
    endtask

    task automatic finish_frame(input int exp_cycles, input bit poke);
        int n = 0;
        while (!frame_done && n < 6000) begin
            step();
            n++;
        end
        chk("frame_done_seen", int'(frame_done), 1);
        if (exp_cycles > 0) chk("frame_cycles", cyc - t0, exp_cycles);
        chk("frame_beats", beats - b0, NUM_COLS);
        if (poke) begin
            heading = 9'd45;
            start   = 1'b1;
        end
        step();
        start = 1'b0;
        step();
        chk("busy_after_done", int'(busy), 0);
        chk("frame_done_count", dones - d0, 1);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        logic signed [9:0] s_x, s_y, s_c;
        logic [8:0]        s_a;
        logic [9:0]        s_col;

        for (int d = 0; d < 360; d++) cos_tab[d] = 10'(rnd32($cos(rad(d))));

        #1 Reset_n = 1'b0;
        #1;
        chk("rst_dir_valid", int'(dir_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_dir_x", int'(dir_x), 0);
        chk("rst_col", int'(col), 0);
        chk("rst_lut_angle", int'(lut_angle), 0);
        chk("rst_corr", int'($signed(corr)), 32);
        step();
        step();
        Reset_n = 1'b1;
        step();
        step();

        // Basic frame
        start_frame(30);
        finish_frame(NUM_COLS * CPB + 1, 1'b0);

        // Wrap through 359 -> 0
        start_frame(0);
        finish_frame(NUM_COLS * CPB + 1, 1'b0);

        // Stall at column 10
        start_frame(100);
        wait_col(10);
        dir_ready = 1'b0;
        for (int n = 0; n < 20 && !dir_valid; n++) step();
        chk("stall_valid_up", int'(dir_valid), 1);
        s_x = dir_x; s_y = dir_y; s_a = ray_angle; s_col = col; s_c = corr;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", int'(dir_valid), 1);
            chk("stall_dir_x", int'(dir_x), int'(s_x));
            chk("stall_dir_y", int'(dir_y), int'(s_y));
            chk("stall_angle", int'(ray_angle), int'(s_a));
            chk("stall_col", int'(col), int'(s_col));
            chk("stall_corr", int'(corr), int'(s_c));
            chk("stall_lut_angle", int'(lut_angle), 0);
            if (i < 4) step();
        end
        dir_ready = 1'b1;
        step();
        chk("resume_col", int'(col), 11);
        chk("resume_valid", int'(dir_valid), 0);
        chk("resume_lut_angle", int'(lut_angle), exp_angle(100, 11));
        finish_frame(0, 1'b0);

        // Start while busy, and start in the DONE cycle, are both dropped
        start_frame(200);
        wait_col(50);
        heading = 9'd7;
        start   = 1'b1;
        step();
        start   = 1'b0;
        finish_frame(NUM_COLS * CPB + 1, 1'b1);

        // Reset mid-frame
        start_frame(30);
        wait_col(100);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(dir_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_col", int'(col), 0);
        chk("mid_rst_angle", int'(ray_angle), 0);
        chk("mid_rst_dir_x", int'(dir_x), 0);
        chk("mid_rst_dir_y", int'(dir_y), 0);
        chk("mid_rst_lut_angle", int'(lut_angle), 0);
        chk("mid_rst_corr", int'($signed(corr)), 32);
        sb.delete();
        d0 = dones;
        step();
        step();
        Reset_n = 1'b1;
        heading = 9'd30;
        start   = 1'b1;
        step();
        start   = 1'b0;
        chk("start_at_release_ignored", int'(busy), 0);
        for (int i = 0; i < 5; i++) step();
        chk("no_done_after_reset", dones - d0, 0);
        start_frame(30);
        finish_frame(NUM_COLS * CPB + 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
